// File: rtl/tl_merged_phit_serializer.sv
// Serializes one merged TileLink beat (164-bit packed) into N_BEATS phits of PHIT_W bits,
// LSB-first, with zero-bubble reload on the final phit.
module tl_merged_phit_serializer #(
    parameter int unsigned PHIT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              io_in_ready,
    input  logic              io_in_valid,
    input  logic [2:0]        io_in_bits_chanId,
    input  logic [2:0]        io_in_bits_opcode,
    input  logic [2:0]        io_in_bits_param,
    input  logic [7:0]        io_in_bits_size,
    input  logic [7:0]        io_in_bits_source,
    input  logic [63:0]       io_in_bits_address,
    input  logic [63:0]       io_in_bits_data,
    input  logic              io_in_bits_corrupt,
    input  logic [8:0]        io_in_bits_union,
    input  logic              io_in_bits_last,
    input  logic              io_out_ready,
    output logic              io_out_valid,
    output logic [PHIT_W-1:0] io_out_bits
);

    localparam int unsigned FLAT_W  = 164;
    localparam int unsigned N_BEATS = (FLAT_W + PHIT_W - 1) / PHIT_W;
    localparam int unsigned CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int unsigned SH_W    = N_BEATS * PHIT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [SH_W-1:0]   shreg, shreg_nxt;
    logic [SH_W-1:0]   flat;
    logic              last_phit;
    logic              in_fire;
    logic              out_fire;

    // Zero-padded to a whole number of phits so the final shift never exposes stale bits.
    always_comb begin
        flat = '0;
        flat[FLAT_W-1:0] = {io_in_bits_chanId, io_in_bits_opcode, io_in_bits_param,
                            io_in_bits_size, io_in_bits_source, io_in_bits_address,
                            io_in_bits_data, io_in_bits_corrupt, io_in_bits_union,
                            io_in_bits_last};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;

        // Ready looks through to out_ready on the last phit so the next beat loads without a gap.
        last_phit    = (cnt == CNT_LAST);
        io_out_valid = reset & (state == SEND);
        io_in_ready  = reset & ((state == IDLE) | (last_phit & io_out_ready));
        io_out_bits  = shreg[PHIT_W-1:0];
        in_fire      = io_in_valid & io_in_ready;
        out_fire     = io_out_valid & io_out_ready;

        case (state)
            IDLE: begin
                if (in_fire) begin
                    shreg_nxt = flat;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (!last_phit) begin
                        shreg_nxt = shreg >> PHIT_W;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end else if (in_fire) begin
                        shreg_nxt = flat;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
